fnd_display_arbiter: RTL and testbench

//  Shares the 4-digit FND display (fnd_controller) between the watch-time source and the stopwatch source.

---
 rtl/fnd_display_arbiter_pkg.sv | 20 ++
 rtl/fnd_display_arbiter_blink_timer.sv | 62 ++++++
 rtl/fnd_display_arbiter.sv | 127 ++++++++++++
 tb/tb_fnd_display_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_display_arbiter_pkg.sv
// Shared definitions for the FND display arbiter: view/mode encodings,
// display value limit and the clamp helper used by the output mux.
package fnd_display_arbiter_pkg;

  // The state encoding doubles as the cur_mode output code.
  typedef enum logic [1:0] {
    MODE_TIME  = 2'b00,
    MODE_SW    = 2'b01,
    MODE_ALARM = 2'b10
  } mode_e;

  localparam int          DATA_W      = 14;
  localparam logic [13:0] FND_MAX_VAL = 14'd9999;

  // Saturate a 14-bit binary value to the 4-digit display range.
  function automatic logic [13:0] clamp_val(input logic [13:0] x);
    return (x > FND_MAX_VAL) ? FND_MAX_VAL : x;
  endfunction

endpackage

// File: rtl/fnd_display_arbiter_blink_timer.sv
// Millisecond prescaler plus blink half-period counter. The prescaler runs
// freely from reset; clr restarts only the blink counter and phase so a new
// view always starts in its visible half.
module fnd_blink_timer #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BLINK_MS = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic ms_tick,
  output logic blink_phase
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW       = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  assign ms_tick     = (presc_q == PRESC_LAST);
  assign blink_phase = phase_q;

  // Next-state for prescaler, blink counter and blink phase.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    presc_d     = ms_tick ? '0 : presc_q + PW'(1);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (clr) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (ms_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Timer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!reset) begin
      presc_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

endmodule

// File: rtl/fnd_display_arbiter.sv
// Shares the 4-digit FND between the watch and stopwatch sources, overlays a
// timed alarm flash, clamps the selected value and registers display outputs.
module fnd_display_arbiter
  import fnd_display_arbiter_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int BLINK_MS      = 500,
  parameter int ALARM_HOLD_MS = 3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_btn,
  input  logic [13:0] time_data,
  input  logic [13:0] sw_data,
  input  logic [3:0]  edit_mask,
  input  logic        alarm_req,
  input  logic        alarm_ack,
  output logic [13:0] disp_data,
  output logic [3:0]  digit_blank,
  output logic [1:0]  cur_mode,
  output logic        alarm_active
);

  localparam int HW = (ALARM_HOLD_MS > 1) ? $clog2(ALARM_HOLD_MS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(ALARM_HOLD_MS - 1);

  mode_e         state_q, state_d;
  mode_e         ret_q, ret_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          alarm_req_q;
  logic          alarm_rise;
  logic          ms_tick;
  logic          blink_phase;
  logic          blink_clr;

  logic [13:0]   disp_q, disp_d;
  logic [3:0]    blank_q, blank_d;
  logic [1:0]    mode_q, mode_d;
  logic          alarm_act_q, alarm_act_d;

  // Edge register is cleared by reset, so a request already high at release
  // is seen as a fresh rising edge.
  assign alarm_rise = alarm_req & ~alarm_req_q;
  assign blink_clr  = (state_d != state_q);

  fnd_blink_timer #(
    .CLK_HZ   (CLK_HZ),
    .BLINK_MS (BLINK_MS)
  ) u_blink (
    .clk         (clk),
    .reset       (reset),
    .clr         (blink_clr),
    .ms_tick     (ms_tick),
    .blink_phase (blink_phase)
  );

  // View FSM next-state: alarm edge beats mode_btn; ALARM ignores mode_btn
  // and further edges, and returns on ack or hold expiry.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    hold_d  = hold_q;
    case (state_q)
      MODE_TIME, MODE_SW: begin
        if (alarm_rise) begin
          state_d = MODE_ALARM;
          ret_d   = state_q;
          hold_d  = '0;
        end else if (mode_btn) begin
          state_d = (state_q == MODE_TIME) ? MODE_SW : MODE_TIME;
        end
      end
      MODE_ALARM: begin
        if (alarm_ack) begin
          state_d = ret_q;
        end else if (ms_tick) begin
          if (hold_q == HOLD_LAST) state_d = ret_q;
          else                     hold_d  = hold_q + HW'(1);
        end
      end
      default: state_d = MODE_TIME;
    endcase
  end

  // Output mux: source select, clamp and blank mask from the current view.
  always_comb begin
    disp_d      = clamp_val(time_data);
    blank_d     = 4'b0000;
    mode_d      = state_q;
    alarm_act_d = (state_q == MODE_ALARM);
    case (state_q)
      MODE_TIME:  blank_d = edit_mask & {4{blink_phase}};
      MODE_SW:    disp_d  = clamp_val(sw_data);
      MODE_ALARM: blank_d = {4{blink_phase}};
      default:    ;
    endcase
  end

  // State, hold counter, edge register and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= MODE_TIME;
      ret_q       <= MODE_TIME;
      hold_q      <= '0;
      alarm_req_q <= 1'b0;
      disp_q      <= '0;
      blank_q     <= '0;
      mode_q      <= MODE_TIME;
      alarm_act_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      hold_q      <= hold_d;
      alarm_req_q <= alarm_req;
      disp_q      <= disp_d;
      blank_q     <= blank_d;
      mode_q      <= mode_d;
      alarm_act_q <= alarm_act_d;
    end
  end

  assign disp_data    = disp_q;
  assign digit_blank  = blank_q;
  assign cur_mode     = mode_q;
  assign alarm_active = alarm_act_q;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Bench for fnd_display_arbiter: a timeline-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fnd_display_arbiter;

  localparam int CLK_HZ     = 10_000;
  localparam int BLINK_MS   = 2;
  localparam int HOLD_MS    = 5;
  localparam int CYC_PER_MS = CLK_HZ / 1000;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        mode_btn  = 1'b0;
  logic        alarm_req = 1'b0;
  logic        alarm_ack = 1'b0;
  logic [13:0] time_data = '0;
  logic [13:0] sw_data   = '0;
  logic [3:0]  edit_mask = '0;
  logic [13:0] disp_data;
  logic [3:0]  digit_blank;
  logic [1:0]  cur_mode;
  logic        alarm_active;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fnd_display_arbiter #(
    .CLK_HZ        (CLK_HZ),
    .BLINK_MS      (BLINK_MS),
    .ALARM_HOLD_MS (HOLD_MS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mode_btn     (mode_btn),
    .time_data    (time_data),
    .sw_data      (sw_data),
    .edit_mask    (edit_mask),
    .alarm_req    (alarm_req),
    .alarm_ack    (alarm_ack),
    .disp_data    (disp_data),
    .digit_blank  (digit_blank),
    .cur_mode     (cur_mode),
    .alarm_active (alarm_active)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model. Views: 0 TIME, 1 SW, 2 ALARM. Time is measured in edges
  // since reset; blink phase and alarm hold come from ms ticks counted since
  // the last view change.
  int m_view = 0, m_ret = 0, m_edges = 0, m_ticks_view = 0, m_ticks_alarm = 0;
  bit m_req_prev = 0, m_valid = 0;
  int e_disp = 0, e_blank = 0, e_mode = 0, e_alarm = 0;

  function automatic int clampv(input int x);
    return (x > 9999) ? 9999 : x;
  endfunction

  // Advance the model on every rising edge using the inputs it samples.
  always @(posedge clk) begin
    bit tick, phase, rise;
    int nv;
    if (!reset) begin
      m_view = 0; m_ret = 0; m_edges = 0; m_ticks_view = 0; m_ticks_alarm = 0;
      m_req_prev = 0; m_valid = 1;
      e_disp = 0; e_blank = 0; e_mode = 0; e_alarm = 0;
    end else if (m_valid) begin
      m_edges++;
      tick  = (m_edges % CYC_PER_MS) == 0;
      phase = ((m_ticks_view / BLINK_MS) % 2) == 1;
      e_mode  = m_view;
      e_alarm = (m_view == 2) ? 1 : 0;
      e_disp  = clampv((m_view == 1) ? int'(sw_data) : int'(time_data));
      if (m_view == 0)      e_blank = phase ? int'(edit_mask) : 0;
      else if (m_view == 2) e_blank = phase ? 15 : 0;
      else                  e_blank = 0;
      rise = alarm_req && !m_req_prev;
      nv = m_view;
      if (m_view != 2) begin
        if (rise) begin nv = 2; m_ret = m_view; end
        else if (mode_btn) nv = 1 - m_view;
      end else if (alarm_ack || (tick && m_ticks_alarm + 1 >= HOLD_MS)) begin
        nv = m_ret;
      end
      if (nv != m_view) begin
        m_ticks_view = 0; m_ticks_alarm = 0;
      end else if (tick) begin
        m_ticks_view++; m_ticks_alarm++;
      end
      m_view = nv;
      m_req_prev = alarm_req;
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model disp_data", int'(disp_data), e_disp);
      check("model digit_blank", int'(digit_blank), e_blank);
      check("model cur_mode", int'(cur_mode), e_mode);
      check("model alarm_active", int'(alarm_active), e_alarm);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_btn();
    mode_btn = 1'b1;
    step(1);
    mode_btn = 1'b0;
  endtask

  // Return at a negedge just before an ms-tick edge.
  task automatic align_tick();
    for (int i = 0; i < CYC_PER_MS && (m_edges % CYC_PER_MS) != CYC_PER_MS - 1; i++)
      @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_on, n_off, n_alarm, n_dark;

    // 1. Reset for 3 clocks, then release.
    time_data = 14'd1234;
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(1);
    check("t1 disp", int'(disp_data), 1234);
    check("t1 mode", int'(cur_mode), 0);
    check("t1 blank", int'(digit_blank), 0);
    check("t1 alarm", int'(alarm_active), 0);

    // 2. Toggle TIME -> SW -> TIME; an ack outside ALARM is ignored.
    sw_data = 14'd567;
    pulse_btn();
    step(1);
    check("t2 sw mode", int'(cur_mode), 1);
    check("t2 sw disp", int'(disp_data), 567);
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    step(1);
    check("t2 ack ignored", int'(cur_mode), 1);
    edit_mask = 4'b0011;
    pulse_btn();
    step(1);
    check("t2 time mode", int'(cur_mode), 0);
    check("t2 time disp", int'(disp_data), 1234);

    // 3. Edit blink: 20 clk visible / 20 clk blank once settled.
    step(25);
    n_on = 0; n_off = 0;
    for (int i = 0; i < 80; i++) begin
      if (digit_blank == 4'b0011) n_on++;
      else if (digit_blank == 4'b0000) n_off++;
      step(1);
    end
    check("t3 blank cycles", n_on, 40);
    check("t3 visible cycles", n_off, 40);

    // 4. In SW, alarm rises at a tick edge and stays high.
    pulse_btn();
    step(2);
    align_tick();
    alarm_req = 1'b1;
    step(1);
    n_alarm = 0; n_dark = 0;
    for (int i = 0; i < 80; i++) begin
      if (cur_mode == 2'b10) n_alarm++;
      if (digit_blank == 4'b1111) n_dark++;
      if (i == 10) begin
        check("t4 alarm disp", int'(disp_data), 1234);
        check("t4 alarm flag", int'(alarm_active), 1);
      end
      mode_btn = (i == 30);
      step(1);
    end
    mode_btn = 1'b0;
    check("t4 alarm cycles", n_alarm, 50);
    check("t4 dark cycles", n_dark, 20);
    check("t4 back to sw", int'(cur_mode), 1);
    n_alarm = 0;
    for (int i = 0; i < 30; i++) begin
      if (cur_mode == 2'b10) n_alarm++;
      step(1);
    end
    check("t4 no reentry", n_alarm, 0);

    // 5. Alarm edge and mode_btn together in TIME; ack returns to TIME.
    alarm_req = 1'b0;
    step(2);
    pulse_btn();
    step(2);
    check("t5 start time", int'(cur_mode), 0);
    alarm_req = 1'b1;
    mode_btn  = 1'b1;
    step(1);
    mode_btn  = 1'b0;
    step(1);
    check("t5 alarm mode", int'(cur_mode), 2);
    check("t5 alarm flag", int'(alarm_active), 1);
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    step(1);
    check("t5 ret mode", int'(cur_mode), 0);
    check("t5 ret flag", int'(alarm_active), 0);
    step(3);
    check("t5 stays time", int'(cur_mode), 0);

    // 6. Clamp, then reset in the middle of ALARM.
    time_data = 14'd16383;
    step(2);
    check("t6 clamp", int'(disp_data), 9999);
    alarm_req = 1'b0;
    step(1);
    alarm_req = 1'b1;
    step(3);
    check("t6 alarm mode", int'(cur_mode), 2);
    check("t6 alarm disp", int'(disp_data), 9999);
    alarm_req = 1'b0;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("t6 rst mode", int'(cur_mode), 0);
    check("t6 rst flag", int'(alarm_active), 0);
    check("t6 rst blank", int'(digit_blank), 0);
    check("t6 rst disp", int'(disp_data), 0);
    step(1);
    check("t6 post disp", int'(disp_data), 9999);
    check("t6 post mode", int'(cur_mode), 0);

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
